// File: rtl/spike_rate_decoder_pkg.sv
// Shared widths, saturation limit and transmit-state encoding for the spike-rate decoder.
package spike_dec_pkg;
  localparam int NUM_CH_DEF = 3;
  localparam int CNT_W_DEF  = 8;
  localparam int WIN_W_DEF  = 8;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SENDH,
    SEND0,
    SEND1,
    SEND2
  } tx_state_t;
endpackage

// File: rtl/spike_rate_decoder_channel_counter.sv
// Saturating per-channel spike counter. o_capture is the count including this
// cycle's increment, so a clear can snapshot the end-of-window cycle's spike.
module spike_channel_counter
  import spike_dec_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_inc,
  input  logic                 i_clr,
  output logic [CNT_W_DEF-1:0] o_capture
);
  logic [CNT_W_DEF-1:0] r_cnt;

  assign o_capture = (i_inc && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_capture;
    end
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: windowed per-channel spike counts streamed out as bytes.
// Define SPIKE_DEC_FRAME_IDX_EN to prefix every frame with a frame-index byte.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WIN_W  = WIN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] spike_in,
  input  logic [WIN_W-1:0]  window_len,
  output logic [CNT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output tx_state_t         dbg_state
);
  // Handshake: a byte moves on a cycle where out_valid & out_ready; while
  // out_valid is high and out_ready low, out_data and the state do not change.

  logic [WIN_W-1:0] r_win_cnt;
  logic [WIN_W-1:0] w_len_m1;
  logic             w_win_end;
  logic [CNT_W-1:0] w_capture [NUM_CH];
  logic [CNT_W-1:0] r_snap    [NUM_CH];
  tx_state_t        r_state;
  logic [CNT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;
  logic             w_xfer;
  logic             w_accept;

  // window_len of 0 wraps to all-ones here, which is exactly a 2^WIN_W window.
  assign w_len_m1  = window_len - WIN_W'(1);
  assign w_win_end = enable && (r_win_cnt >= w_len_m1);
  assign w_xfer    = r_out_valid && out_ready;
  assign w_accept  = w_win_end && ((r_state == IDLE) || (w_xfer && (r_state == SEND2)));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spike_channel_counter u_cnt (
      .clk       (clk),
      .reset     (reset),
      .i_inc     (enable & spike_in[g]),
      .i_clr     (w_win_end),
      .o_capture (w_capture[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt <= '0;
    end else if (w_win_end) begin
      r_win_cnt <= '0;
    end else if (enable) begin
      r_win_cnt <= r_win_cnt + 1'b1;
    end
  end

`ifdef SPIKE_DEC_FRAME_IDX_EN
  logic [CNT_W-1:0] r_frame_idx;
  logic [CNT_W-1:0] w_frame_next;

  assign w_frame_next = r_frame_idx + 1'b1;

  // Dropped frames still advance the index so the host can see the gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_idx <= '0;
    end else if (w_win_end) begin
      r_frame_idx <= w_frame_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_snap[i] <= '0;
    end else begin
      if (w_win_end && !w_accept) begin
        r_overrun <= 1'b1;
      end
      if (w_accept) begin
        for (int i = 0; i < NUM_CH; i++) r_snap[i] <= w_capture[i];
        r_out_valid <= 1'b1;
`ifdef SPIKE_DEC_FRAME_IDX_EN
        r_state     <= SENDH;
        r_out_data  <= w_frame_next;
`else
        r_state     <= SEND0;
        r_out_data  <= w_capture[0];
`endif
      end else if (w_xfer) begin
        case (r_state)
          SENDH: begin
            r_state    <= SEND0;
            r_out_data <= r_snap[0];
          end
          SEND0: begin
            r_state    <= SEND1;
            r_out_data <= r_snap[1];
          end
          SEND1: begin
            r_state    <= SEND2;
            r_out_data <= r_snap[2];
          end
          default: begin
            r_state     <= IDLE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus random
// traffic, compared every cycle against a frame-queue reference model.
module tb_spike_rate_decoder;
  import spike_dec_pkg::*;

`ifdef SPIKE_DEC_FRAME_IDX_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] spike_in = '0;
  logic [7:0] window_len = 8'd4;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overrun;
  tx_state_t  dbg_state;

  int checks = 0;
  int failures = 0;

  // Reference model: bytes of the frame in flight (head = byte on the bus).
  logic [7:0] exp_q[$];
  int         m_cnt[3];
  int         m_win;
  int         m_frame;
  logic       m_ovr;

  spike_rate_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spike_in   (spike_in),
    .window_len (window_len),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int c = 0; c < 3; c++) m_cnt[c] = 0;
    m_win = 0;
    m_frame = 0;
    m_ovr = 1'b0;
  endtask

  // One clock of the behaviour: pop a transferred byte, count, close windows.
  task automatic model_update();
    int eff;
    if (reset) begin
      model_clear();
      return;
    end
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (enable) begin
      eff = (window_len == 0) ? 256 : int'(window_len);
      for (int c = 0; c < 3; c++)
        if (spike_in[c] && m_cnt[c] < 255) m_cnt[c]++;
      if (m_win >= eff - 1) begin
        m_frame = (m_frame + 1) % 256;
        if (exp_q.size() == 0) begin
`ifdef SPIKE_DEC_FRAME_IDX_EN
          exp_q.push_back(8'(m_frame));
`endif
          for (int c = 0; c < 3; c++) exp_q.push_back(8'(m_cnt[c]));
        end else begin
          m_ovr = 1'b1;
        end
        for (int c = 0; c < 3; c++) m_cnt[c] = 0;
        m_win = 0;
      end else begin
        m_win++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("out_valid", out_valid, (exp_q.size() > 0) ? 1 : 0);
    check("out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : 0);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    spike_in = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    model_clear();

    // Reset state
    steps(2);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    // Basic frame: four enabled cycles with channel 0 firing each time
    window_len = 8'd4; enable = 1'b1; spike_in = 3'b001; out_ready = 1'b1;
    steps(4);
    check("basic_valid_rise", out_valid, 1);
    enable = 1'b0; spike_in = '0;
    steps(FRAME_LEN);
    check("basic_drained", out_valid, 0);

    // Backpressure: hold ten cycles, then exactly one frame drains
    do_reset();
    window_len = 8'd4; enable = 1'b1; spike_in = 3'b011; out_ready = 1'b0;
    steps(4);
    enable = 1'b0; spike_in = '0;
    steps(10);
    check("bp_held_valid", out_valid, 1);
    out_ready = 1'b1;
    steps(FRAME_LEN);
    check("bp_drained", out_valid, 0);
    steps(2);

    // Overrun: second window closes while the first frame is stalled
    do_reset();
    window_len = 8'd2; enable = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      spike_in = 3'($urandom_range(0, 7));
      step();
    end
    check("ovr_set", overrun, 1);
    enable = 1'b0; spike_in = '0; out_ready = 1'b1;
    steps(FRAME_LEN + 2);
    check("ovr_sticky", overrun, 1);
    check("ovr_drained", out_valid, 0);

    // Back-to-back: window length equal to frame length, no bubble, no overrun
    do_reset();
    window_len = 8'(FRAME_LEN); enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4 * FRAME_LEN; k++) begin
      spike_in = 3'($urandom_range(0, 7));
      step();
    end
    check("b2b_overrun", overrun, 0);
    check("b2b_valid", out_valid, 1);

    // Saturation over a 256-cycle window
    do_reset();
    window_len = 8'd0; enable = 1'b1; spike_in = 3'b111; out_ready = 1'b1;
    steps(256);
`ifdef SPIKE_DEC_FRAME_IDX_EN
    step();
`endif
    check("sat_byte0", out_data, 255);
    step();
    check("sat_byte1", out_data, 255);
    step();
    check("sat_byte2", out_data, 255);
    enable = 1'b0; spike_in = '0;
    steps(2);

    // Reset while the frame is mid-stream, then a fresh frame from zero
    do_reset();
    window_len = 8'd4; enable = 1'b1; spike_in = 3'b010; out_ready = 1'b1;
    steps(FRAME_LEN - 1);
    spike_in = 3'b001;
    steps(3);
    reset = 1'b1;
    step();
    check("rst_mid_valid", out_valid, 0);
    reset = 1'b0;
    spike_in = 3'b001;
    steps(4);
    enable = 1'b0; spike_in = '0;
    steps(FRAME_LEN);

    // Enable low mid-window freezes the counts
    do_reset();
    window_len = 8'd6; enable = 1'b1; spike_in = 3'b001;
    steps(3);
    enable = 1'b0; spike_in = 3'b111;
    steps(5);
    enable = 1'b1; spike_in = 3'b001;
    steps(3);
    enable = 1'b0; spike_in = '0;
`ifdef SPIKE_DEC_FRAME_IDX_EN
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif
    check("en_hold_cnt", out_data, 6);
    out_ready = 1'b1;
    steps(FRAME_LEN);

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      enable    = ($urandom_range(0, 9) < 8);
      spike_in  = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 40) == 0) window_len = 8'($urandom_range(0, 8));
      reset     = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
